gpio_in_cond: RTL and testbench

Input conditioning stage between the GPIO pads and the `multi_gpio_ip` block's `gpio_in` port. It provides:
- a 2-flop synchronizer per bit;
- a shared-tick 3-sample debouncer;
- rising/falling edge detection with a sticky, write-1-to-clear interrupt status and a single level `irq`.

It has its own small register window on the same simple valid/we bus as the GPIO block.

---
 rtl/gpio_pkg.sv | 23 ++
 rtl/gpio_deb_bit.sv | 69 ++++++
 rtl/gpio_in_cond.sv | 130 +++++++++++++
 tb/tb_gpio_in_cond.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants for the GPIO block and its input conditioning stage:
// register offsets for both register windows and default widths.
package gpio_pkg;

  // Default widths.
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEB_W = 16;

  // Existing multi_gpio_ip register offsets.
  localparam logic [7:0] GPIO_OUT_OFS = 8'h00;
  localparam logic [7:0] GPIO_OE_OFS  = 8'h04;
  localparam logic [7:0] GPIO_IN_OFS  = 8'h08;

  // Input conditioning register offsets.
  localparam logic [7:0] COND_DEB_CFG_OFS    = 8'h00;
  localparam logic [7:0] COND_RISE_EN_OFS    = 8'h04;
  localparam logic [7:0] COND_FALL_EN_OFS    = 8'h08;
  localparam logic [7:0] COND_IRQ_STATUS_OFS = 8'h0C;
  localparam logic [7:0] COND_RAW_OFS        = 8'h10;
  localparam logic [7:0] COND_CLEAN_OFS      = 8'h14;

endpackage

// File: rtl/gpio_deb_bit.sv
// gpio_deb_bit
// Conditioning for a single pad bit: 2-flop synchronizer, 2-entry sample
// history and the debounced output flop. rise_o/fall_o describe the change
// that clean_o is about to make on the coming clock edge.
//
// Ports
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   pad_i     in  raw asynchronous pad level
//   tick_i    in  shared sample tick from the prescaler
//   bypass_i  in  1 = copy the synchronized level straight to clean_o
//   raw_o     out synchronized level before debounce
//   clean_o   out conditioned level
//   rise_o    out clean_o goes 0->1 on the next edge
//   fall_o    out clean_o goes 1->0 on the next edge
module gpio_deb_bit (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  input  logic tick_i,
  input  logic bypass_i,
  output logic raw_o,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  logic       s1_q;
  logic       s2_q;
  logic [1:0] hist_q;
  logic [1:0] hist_d;
  logic       clean_q;
  logic       clean_d;

  // The history holds the two previous tick samples, so together with the
  // current synchronized value three agreeing samples are needed to move.
  always_comb begin
    hist_d  = hist_q;
    clean_d = clean_q;
    if (tick_i) begin
      hist_d = {hist_q[0], s2_q};
    end
    if (bypass_i) begin
      clean_d = s2_q;
    end else if (tick_i && (hist_q[1] == hist_q[0]) && (hist_q[0] == s2_q)) begin
      clean_d = s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      hist_q  <= 2'b00;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= pad_i;
      s2_q    <= s1_q;
      hist_q  <= hist_d;
      clean_q <= clean_d;
    end
  end

  assign raw_o   = s2_q;
  assign clean_o = clean_q;
  assign rise_o  = ~clean_q & clean_d;
  assign fall_o  = clean_q & ~clean_d;

endmodule

// File: rtl/gpio_in_cond.sv
// gpio_in_cond
// Input conditioning between the GPIO pads and multi_gpio_ip.gpio_in:
// per-bit synchronizer and shared-tick 3-sample debouncer, edge detection
// into a sticky write-1-to-clear status register, and a level interrupt.
//
// Ports
//   clk            in  clock
//   rst            in  asynchronous active-high reset
//   pad_in         in  raw pad levels [WIDTH]
//   gpio_in_clean  out conditioned levels [WIDTH]
//   bus_valid      in  single-cycle access strobe
//   bus_we         in  1 = write, 0 = read
//   bus_addr       in  byte address, [7:0] decoded
//   bus_wdata      in  write data
//   bus_rdata      out read data, combinational from bus_addr
//   irq            out OR of IRQ_STATUS
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEB_W = DEFAULT_DEB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] gpio_in_clean,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             irq
);

  logic [DEB_W-1:0] debCfg_q, debCfg_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] riseEn_q, riseEn_d;
  logic [WIDTH-1:0] fallEn_q, fallEn_d;
  logic [WIDTH-1:0] irqStatus_q, irqStatus_d;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] w1c;
  logic             wrEn;
  logic             tick;
  logic             bypass;
  logic             unusedBus;

  assign wrEn   = bus_valid & bus_we;
  assign bypass = (debCfg_q == '0);
  // In bypass the compare is always true, so history keeps tracking s2 and
  // is already settled if debounce is switched on later.
  assign tick   = (cnt_q == debCfg_q);

  // Only the low address byte and the low data bits are meaningful.
  assign unusedBus = ^{bus_addr[31:8], bus_wdata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_deb_bit u_deb (
      .clk      (clk),
      .rst      (rst),
      .pad_i    (pad_in[i]),
      .tick_i   (tick),
      .bypass_i (bypass),
      .raw_o    (raw[i]),
      .clean_o  (clean[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  // Register writes, prescaler and status next-state. New events are OR-ed
  // in after the clear so a set on the same edge as a W1C wins.
  always_comb begin
    debCfg_d = debCfg_q;
    riseEn_d = riseEn_q;
    fallEn_d = fallEn_q;
    w1c      = '0;
    cnt_d    = tick ? '0 : cnt_q + DEB_W'(1);
    if (wrEn) begin
      case (bus_addr[7:0])
        COND_DEB_CFG_OFS: begin
          debCfg_d = bus_wdata[DEB_W-1:0];
          cnt_d    = '0;
        end
        COND_RISE_EN_OFS:    riseEn_d = bus_wdata[WIDTH-1:0];
        COND_FALL_EN_OFS:    fallEn_d = bus_wdata[WIDTH-1:0];
        COND_IRQ_STATUS_OFS: w1c      = bus_wdata[WIDTH-1:0];
        default: ;
      endcase
    end
    irqStatus_d = (irqStatus_q & ~w1c) | (rise & riseEn_q) | (fall & fallEn_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debCfg_q    <= '0;
      cnt_q       <= '0;
      riseEn_q    <= '0;
      fallEn_q    <= '0;
      irqStatus_q <= '0;
    end else begin
      debCfg_q    <= debCfg_d;
      cnt_q       <= cnt_d;
      riseEn_q    <= riseEn_d;
      fallEn_q    <= fallEn_d;
      irqStatus_q <= irqStatus_d;
    end
  end

  // Read decode has no side effects; unmapped offsets return zero.
  always_comb begin
    bus_rdata = '0;
    case (bus_addr[7:0])
      COND_DEB_CFG_OFS:    bus_rdata = 32'(debCfg_q);
      COND_RISE_EN_OFS:    bus_rdata = 32'(riseEn_q);
      COND_FALL_EN_OFS:    bus_rdata = 32'(fallEn_q);
      COND_IRQ_STATUS_OFS: bus_rdata = 32'(irqStatus_q);
      COND_RAW_OFS:        bus_rdata = 32'(raw);
      COND_CLEAN_OFS:      bus_rdata = 32'(clean);
      default: ;
    endcase
  end

  assign gpio_in_clean = clean;
  assign irq           = |irqStatus_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond
// Directed bench for gpio_in_cond: reset, bypass latency, edge interrupts,
// debounce glitch rejection, set/clear collision and register decode.
module tb_gpio_in_cond;

  logic        clk;
  logic        rst;
  logic [31:0] pad_in;
  logic [31:0] gpio_in_clean;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_DEB   = 32'h00;
  localparam logic [31:0] A_RISE  = 32'h04;
  localparam logic [31:0] A_FALL  = 32'h08;
  localparam logic [31:0] A_STAT  = 32'h0C;
  localparam logic [31:0] A_RAW   = 32'h10;
  localparam logic [31:0] A_CLEAN = 32'h14;

  gpio_in_cond dut (
    .clk           (clk),
    .rst           (rst),
    .pad_in        (pad_in),
    .gpio_in_clean (gpio_in_clean),
    .bus_valid     (bus_valid),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving the bench 1 ns after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pad, input int cycles);
    pad_in = pad;
    step(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    step(1);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = '0;
  endtask

  task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = addr;
    #1;
    checkOutput(tag, bus_rdata, exp);
    bus_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    pad_in    = 32'hFFFF_FFFF;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;

    // Reset held with all pads high.
    step(3);
    checkOutput("rst_clean", gpio_in_clean, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkReg("rst_deb", A_DEB, 32'h0);
    checkReg("rst_stat", A_STAT, 32'h0);
    checkReg("rst_raw", A_RAW, 32'h0);

    // Release; bypass latency is three edges.
    rst = 1'b0;
    step(2);
    checkOutput("byp_edge2", gpio_in_clean, 32'h0);
    step(1);
    checkOutput("byp_edge3", gpio_in_clean, 32'hFFFF_FFFF);

    // Drop all pads; no enables so no status.
    applyStimulus(32'h0, 4);
    checkOutput("byp_low", gpio_in_clean, 32'h0);
    checkReg("no_en_stat", A_STAT, 32'h0);

    // Rising edge interrupt on bit 0.
    busWrite(A_RISE, 32'h1);
    applyStimulus(32'h1, 2);
    checkOutput("rise_edge2_irq", {31'h0, irq}, 32'h0);
    step(1);
    checkReg("rise_edge3_stat", A_STAT, 32'h1);
    checkOutput("rise_edge3_irq", {31'h0, irq}, 32'h1);
    busWrite(A_STAT, 32'h1);
    checkOutput("w1c_irq", {31'h0, irq}, 32'h0);
    checkReg("w1c_stat", A_STAT, 32'h0);

    // Debounce with a 4-cycle tick: a 6-cycle pulse must be rejected.
    applyStimulus(32'h0, 4);
    busWrite(A_DEB, 32'h3);
    applyStimulus(32'h20, 6);
    applyStimulus(32'h0, 20);
    checkReg("glitch_clean", A_CLEAN, 32'h0);
    checkReg("glitch_stat", A_STAT, 32'h0);

    // Held level gets through; RAW leads CLEAN.
    applyStimulus(32'h20, 3);
    checkReg("hold_raw", A_RAW, 32'h20);
    checkReg("hold_clean_early", A_CLEAN, 32'h0);
    step(20);
    checkReg("hold_clean", A_CLEAN, 32'h20);
    checkOutput("hold_out", gpio_in_clean, 32'h20);
    checkReg("hold_stat", A_STAT, 32'h0);

    // Fall enable only on bit 31, back in bypass.
    busWrite(A_DEB, 32'h0);
    busWrite(A_RISE, 32'h0);
    busWrite(A_FALL, 32'h8000_0000);
    applyStimulus(32'h8000_0020, 4);
    checkOutput("b31_up_clean", gpio_in_clean, 32'h8000_0020);
    checkReg("b31_up_stat", A_STAT, 32'h0);
    applyStimulus(32'h20, 4);
    checkReg("b31_down_stat", A_STAT, 32'h8000_0000);
    checkOutput("b31_down_irq", {31'h0, irq}, 32'h1);
    busWrite(A_FALL, 32'h0);
    checkReg("en_off_keeps", A_STAT, 32'h8000_0000);
    busWrite(A_STAT, 32'h8000_0000);
    checkReg("b31_cleared", A_STAT, 32'h0);

    // Rise on bit 2 lands on the same edge as a W1C of bit 2.
    busWrite(A_RISE, 32'h4);
    applyStimulus(32'h24, 2);
    busWrite(A_STAT, 32'h4);
    checkReg("collide_stat", A_STAT, 32'h4);
    busWrite(A_STAT, 32'h4);
    checkReg("collide_clear", A_STAT, 32'h0);

    // Bus decode.
    checkReg("unmapped_rd", 32'h18, 32'h0);
    busWrite(A_RAW, 32'h0);
    checkReg("raw_ro", A_RAW, 32'h24);
    busWrite(32'h18, 32'hFFFF_FFFF);
    checkReg("unmapped_wr", 32'h18, 32'h0);
    busWrite(A_DEB, 32'hFFFF_FFFF);
    checkReg("deb_max", A_DEB, 32'h0000_FFFF);
    checkReg("rise_rb", A_RISE, 32'h4);

    // Reset mid-run clears everything, then bypass resumes.
    rst = 1'b1;
    #1;
    checkOutput("rst2_clean", gpio_in_clean, 32'h0);
    checkReg("rst2_deb", A_DEB, 32'h0);
    checkReg("rst2_rise", A_RISE, 32'h0);
    step(2);
    rst = 1'b0;
    step(3);
    checkOutput("rst2_bypass", gpio_in_clean, 32'h24);
    checkOutput("rst2_irq", {31'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
